// File: rtl/open_nic_cmac_sim_port.sv
// Simulation stand-in for one CMAC port: registered RX/TX streams,
// RX frame checking, TX runt padding and per-direction statistics.
module open_nic_cmac_sim_port #(
    parameter int DATA_WIDTH  = 512,
    parameter int MIN_PKT_LEN = 64,
    parameter int MAX_PKT_LEN = 1518
) (
    input  logic                    cmac_clk,
    input  logic                    cmac_rstn,

    input  logic                    s_axis_cmac_rx_sim_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_cmac_rx_sim_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_cmac_rx_sim_tkeep,
    input  logic                    s_axis_cmac_rx_sim_tlast,
    input  logic                    s_axis_cmac_rx_sim_tuser_err,

    output logic                    m_axis_rx_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_rx_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_rx_tkeep,
    output logic                    m_axis_rx_tlast,
    output logic                    m_axis_rx_tuser_err,

    input  logic                    s_axis_tx_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tx_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
    input  logic                    s_axis_tx_tlast,
    output logic                    s_axis_tx_tready,

    output logic                    m_axis_cmac_tx_sim_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_cmac_tx_sim_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_cmac_tx_sim_tkeep,
    output logic                    m_axis_cmac_tx_sim_tlast,
    input  logic                    m_axis_cmac_tx_sim_tready,

    output logic [31:0]             rx_pkt_cnt,
    output logic [31:0]             rx_err_cnt,
    output logic [31:0]             rx_byte_cnt,
    output logic [31:0]             tx_pkt_cnt,
    output logic [31:0]             tx_byte_cnt
);

    localparam int KW = DATA_WIDTH / 8;

    function automatic logic [15:0] popcnt(input logic [KW-1:0] k);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < KW; i++) c = c + {15'b0, k[i]};
        return c;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [KW-1:0] low_mask(input logic [15:0] n);
        logic [KW-1:0] m;
        for (int i = 0; i < KW; i++) m[i] = (16'(i) < n);
        return m;
    endfunction

    // ---------------- RX ----------------
    logic                  rx_vld_q, rx_last_q, rx_uerr_q, rx_err_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [KW-1:0]         rx_keep_q;
    logic [15:0]           rx_len_q, rx_flen_q;
    logic [15:0]           rx_total;
    logic                  rx_bad;
    logic [31:0]           rx_pkt_q, rx_errc_q, rx_byte_q;

    assign rx_total = sat_add(rx_len_q, popcnt(s_axis_cmac_rx_sim_tkeep));
    assign rx_bad   = rx_err_q | s_axis_cmac_rx_sim_tuser_err
                    | (rx_total < 16'(MIN_PKT_LEN))
                    | (rx_total > 16'(MAX_PKT_LEN));

    // Register every RX beat and track per-frame length and sticky error
    always_ff @(posedge cmac_clk or negedge cmac_rstn) begin
        if (!cmac_rstn) begin
            rx_vld_q  <= 1'b0;
            rx_last_q <= 1'b0;
            rx_uerr_q <= 1'b0;
            rx_data_q <= '0;
            rx_keep_q <= '0;
            rx_flen_q <= '0;
            rx_len_q  <= '0;
            rx_err_q  <= 1'b0;
        end else begin
            rx_vld_q  <= s_axis_cmac_rx_sim_tvalid;
            rx_uerr_q <= s_axis_cmac_rx_sim_tvalid & s_axis_cmac_rx_sim_tlast & rx_bad;
            if (s_axis_cmac_rx_sim_tvalid) begin
                rx_data_q <= s_axis_cmac_rx_sim_tdata;
                rx_keep_q <= s_axis_cmac_rx_sim_tkeep;
                rx_last_q <= s_axis_cmac_rx_sim_tlast;
                rx_flen_q <= rx_total;
                if (s_axis_cmac_rx_sim_tlast) begin
                    rx_len_q <= '0;
                    rx_err_q <= 1'b0;
                end else begin
                    rx_len_q <= rx_total;
                    rx_err_q <= rx_err_q | s_axis_cmac_rx_sim_tuser_err;
                end
            end
        end
    end

    // RX statistics follow the registered tlast beat
    always_ff @(posedge cmac_clk or negedge cmac_rstn) begin
        if (!cmac_rstn) begin
            rx_pkt_q  <= '0;
            rx_errc_q <= '0;
            rx_byte_q <= '0;
        end else if (rx_vld_q && rx_last_q) begin
            rx_pkt_q  <= rx_pkt_q + 32'd1;
            rx_errc_q <= rx_errc_q + {31'b0, rx_uerr_q};
            rx_byte_q <= rx_byte_q + {16'b0, rx_flen_q};
        end
    end

    assign m_axis_rx_tvalid    = rx_vld_q;
    assign m_axis_rx_tdata     = rx_data_q;
    assign m_axis_rx_tkeep     = rx_keep_q;
    assign m_axis_rx_tlast     = rx_last_q;
    assign m_axis_rx_tuser_err = rx_uerr_q;
    assign rx_pkt_cnt          = rx_pkt_q;
    assign rx_err_cnt          = rx_errc_q;
    assign rx_byte_cnt         = rx_byte_q;

    // ---------------- TX ----------------
    logic                  tx_rdy_q, tx_fire, tx_runt, out_ready;
    logic [15:0]           tx_len_q, tx_sum, tx_pad_flen;
    logic [KW-1:0]         tx_pad_keep;
    logic [DATA_WIDTH-1:0] tx_pad_data;
    logic                  out_vld_q, out_last_q, skid_vld_q, skid_last_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, skid_data_q;
    logic [KW-1:0]         out_keep_q, skid_keep_q;
    logic [15:0]           out_flen_q, skid_flen_q;
    logic [31:0]           tx_pkt_q, tx_byte_q;

    assign tx_fire     = s_axis_tx_tvalid & tx_rdy_q;
    assign tx_sum      = sat_add(tx_len_q, popcnt(s_axis_tx_tkeep));
    assign tx_runt     = s_axis_tx_tlast & (tx_sum < 16'(MIN_PKT_LEN));
    assign tx_pad_keep = tx_runt ? low_mask(16'(MIN_PKT_LEN) - tx_len_q) : s_axis_tx_tkeep;
    assign tx_pad_flen = tx_runt ? 16'(MIN_PKT_LEN) : tx_sum;
    assign out_ready   = m_axis_cmac_tx_sim_tready | ~out_vld_q;

    // Zero the lanes that padding switched on
    always_comb begin
        tx_pad_data = s_axis_tx_tdata;
        for (int i = 0; i < KW; i++)
            if (tx_pad_keep[i] && !s_axis_tx_tkeep[i]) tx_pad_data[8*i +: 8] = 8'h00;
    end

    // Skid entry fills only when the output is stalled and a beat arrives
    always_comb begin
        skid_vld_d = out_ready ? 1'b0 : (skid_vld_q | tx_fire);
    end

    // Output register plus one skid entry; skid drains first to keep order
    always_ff @(posedge cmac_clk or negedge cmac_rstn) begin
        if (!cmac_rstn) begin
            tx_rdy_q    <= 1'b0;
            tx_len_q    <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_flen_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_keep_q <= '0;
            skid_flen_q <= '0;
        end else begin
            tx_rdy_q   <= ~skid_vld_d;
            skid_vld_q <= skid_vld_d;
            if (tx_fire) tx_len_q <= s_axis_tx_tlast ? 16'd0 : tx_sum;
            if (out_ready) begin
                if (skid_vld_q) begin
                    out_vld_q  <= 1'b1;
                    out_data_q <= skid_data_q;
                    out_keep_q <= skid_keep_q;
                    out_last_q <= skid_last_q;
                    out_flen_q <= skid_flen_q;
                end else begin
                    out_vld_q <= tx_fire;
                    if (tx_fire) begin
                        out_data_q <= tx_pad_data;
                        out_keep_q <= tx_pad_keep;
                        out_last_q <= s_axis_tx_tlast;
                        out_flen_q <= tx_pad_flen;
                    end
                end
            end else if (tx_fire) begin
                skid_data_q <= tx_pad_data;
                skid_keep_q <= tx_pad_keep;
                skid_last_q <= s_axis_tx_tlast;
                skid_flen_q <= tx_pad_flen;
            end
        end
    end

    // TX statistics count the padded frame when its tlast leaves
    always_ff @(posedge cmac_clk or negedge cmac_rstn) begin
        if (!cmac_rstn) begin
            tx_pkt_q  <= '0;
            tx_byte_q <= '0;
        end else if (out_vld_q && m_axis_cmac_tx_sim_tready && out_last_q) begin
            tx_pkt_q  <= tx_pkt_q + 32'd1;
            tx_byte_q <= tx_byte_q + {16'b0, out_flen_q};
        end
    end

    assign s_axis_tx_tready          = tx_rdy_q;
    assign m_axis_cmac_tx_sim_tvalid = out_vld_q;
    assign m_axis_cmac_tx_sim_tdata  = out_data_q;
    assign m_axis_cmac_tx_sim_tkeep  = out_keep_q;
    assign m_axis_cmac_tx_sim_tlast  = out_last_q;
    assign tx_pkt_cnt                = tx_pkt_q;
    assign tx_byte_cnt               = tx_byte_q;

endmodule

// File: tb/tb_open_nic_cmac_sim_port.sv
// Self-checking bench for open_nic_cmac_sim_port: frame-level model
// of RX checking, TX padding/ordering and statistics.
module tb_open_nic_cmac_sim_port;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_v, rx_l, rx_e;
    logic [511:0] rx_d;
    logic [63:0]  rx_k;
    logic         mrx_v, mrx_l, mrx_e;
    logic [511:0] mrx_d;
    logic [63:0]  mrx_k;
    logic         tx_v, tx_l, tx_rdy;
    logic [511:0] tx_d;
    logic [63:0]  tx_k;
    logic         mtx_v, mtx_l;
    logic [511:0] mtx_d;
    logic [63:0]  mtx_k;
    logic         sink_rdy = 1'b1;
    logic         tog_en = 1'b0;
    logic [31:0]  c_rxp, c_rxe, c_rxb, c_txp, c_txb;

    open_nic_cmac_sim_port dut (
        .cmac_clk                     (clk),
        .cmac_rstn                    (rst_n),
        .s_axis_cmac_rx_sim_tvalid    (rx_v),
        .s_axis_cmac_rx_sim_tdata     (rx_d),
        .s_axis_cmac_rx_sim_tkeep     (rx_k),
        .s_axis_cmac_rx_sim_tlast     (rx_l),
        .s_axis_cmac_rx_sim_tuser_err (rx_e),
        .m_axis_rx_tvalid             (mrx_v),
        .m_axis_rx_tdata              (mrx_d),
        .m_axis_rx_tkeep              (mrx_k),
        .m_axis_rx_tlast              (mrx_l),
        .m_axis_rx_tuser_err          (mrx_e),
        .s_axis_tx_tvalid             (tx_v),
        .s_axis_tx_tdata              (tx_d),
        .s_axis_tx_tkeep              (tx_k),
        .s_axis_tx_tlast              (tx_l),
        .s_axis_tx_tready             (tx_rdy),
        .m_axis_cmac_tx_sim_tvalid    (mtx_v),
        .m_axis_cmac_tx_sim_tdata     (mtx_d),
        .m_axis_cmac_tx_sim_tkeep     (mtx_k),
        .m_axis_cmac_tx_sim_tlast     (mtx_l),
        .m_axis_cmac_tx_sim_tready    (sink_rdy),
        .rx_pkt_cnt                   (c_rxp),
        .rx_err_cnt                   (c_rxe),
        .rx_byte_cnt                  (c_rxb),
        .tx_pkt_cnt                   (c_txp),
        .tx_byte_cnt                  (c_txb)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         e;
        int           cyc;
    } rxb_t;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        int           flen;
    } txb_t;

    rxb_t rxq[$];
    txb_t txq[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rx_acc = 0;
    bit          rx_st = 1'b0;
    int          tx_acc = 0;
    logic [31:0] e_rxp = 0, e_rxe = 0, e_rxb = 0, e_txp = 0, e_txb = 0;
    bit          held = 1'b0;
    logic [577:0] held_vec;
    logic [511:0] last_tx_d;
    logic [63:0]  last_tx_k;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink ready: held high, or toggling every cycle when enabled
    initial forever begin
        @(posedge clk);
        #1;
        sink_rdy = tog_en ? ~sink_rdy : 1'b1;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int popc(input logic [63:0] k);
        int c = 0;
        for (int i = 0; i < 64; i++) c += int'(k[i]);
        return c;
    endfunction

    function automatic logic [63:0] kmask(input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [511:0] rnd();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic rx_beat(input logic [511:0] d, input logic [63:0] k,
                           input logic l, input logic e);
        rxb_t b;
        int   tot;
        @(posedge clk);
        #1;
        rx_v = 1'b1; rx_d = d; rx_k = k; rx_l = l; rx_e = e;
        tot = rx_acc + popc(k);
        b.d = d; b.k = k; b.l = l; b.cyc = cyc;
        b.e = l && (rx_st || e || tot < 64 || tot > 1518);
        if (l) begin
            rx_acc = 0;
            rx_st  = 1'b0;
        end else begin
            rx_acc = tot;
            rx_st  = rx_st | e;
        end
        rxq.push_back(b);
    endtask

    task automatic rx_stop();
        @(posedge clk);
        #1;
        rx_v = 1'b0;
    endtask

    task automatic rx_frame(input int len, input int errb);
        int nb = (len == 0) ? 1 : (len + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            int n = (b < nb - 1) ? 64 : len - 64 * (nb - 1);
            rx_beat(rnd(), kmask(n), b == nb - 1, b == errb);
        end
    endtask

    task automatic tx_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
        txb_t b;
        int   w = 0;
        int   p;
        @(posedge clk);
        #1;
        tx_v = 1'b1; tx_d = d; tx_k = k; tx_l = l;
        while (!tx_rdy) begin
            @(posedge clk);
            #1;
            w++;
            if (w > 1000) begin
                $display("FAIL tx_ready_timeout got 0 want 1");
                $fatal(1);
            end
        end
        p = popc(k);
        b.d = d; b.k = k; b.l = l; b.flen = 0;
        if (l) begin
            if (tx_acc + p < 64) begin
                for (int i = 0; i < 64 - tx_acc; i++)
                    if (!k[i]) begin
                        b.k[i] = 1'b1;
                        b.d[8*i +: 8] = 8'h00;
                    end
                b.flen = 64;
            end else begin
                b.flen = tx_acc + p;
            end
            tx_acc = 0;
        end else begin
            tx_acc += p;
        end
        txq.push_back(b);
    endtask

    task automatic tx_stop();
        @(posedge clk);
        #1;
        tx_v = 1'b0;
    endtask

    task automatic tx_frame(input int len);
        int nb = (len + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            int n = (b < nb - 1) ? 64 : len - 64 * (nb - 1);
            tx_beat(rnd(), kmask(n), b == nb - 1);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((rxq.size() != 0 || txq.size() != 0) && w < 500) begin
            @(posedge clk);
            w++;
        end
        chk("drain", 512'(rxq.size() + txq.size()), 512'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_v = 1'b0; rx_l = 1'b0; rx_e = 1'b0;
        tx_v = 1'b0; tx_l = 1'b0;
        rxq.delete();
        txq.delete();
        rx_acc = 0; rx_st = 1'b0; tx_acc = 0;
        e_rxp = 0; e_rxe = 0; e_rxb = 0; e_txp = 0; e_txb = 0;
        held = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_tready", 512'(tx_rdy), 512'd0);
        chk("rst_rxv", 512'(mrx_v), 512'd0);
        chk("rst_txv", 512'(mtx_v), 512'd0);
        chk("rst_cnt", {c_rxp, c_rxe, c_rxb, c_txp, c_txb}, 512'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_tready", 512'(tx_rdy), 512'd1);
    endtask

    // Compare process: counters, RX beats with exact latency, TX order and hold
    initial forever begin
        @(negedge clk);
        chk("rx_pkt_cnt", 512'(c_rxp), 512'(e_rxp));
        chk("rx_err_cnt", 512'(c_rxe), 512'(e_rxe));
        chk("rx_byte_cnt", 512'(c_rxb), 512'(e_rxb));
        chk("tx_pkt_cnt", 512'(c_txp), 512'(e_txp));
        chk("tx_byte_cnt", 512'(c_txb), 512'(e_txb));
        if (rxq.size() > 0 && rxq[0].cyc + 1 == cyc) begin
            chk("rx_valid", 512'(mrx_v), 512'd1);
            chk("rx_data", mrx_d, rxq[0].d);
            chk("rx_keep", 512'(mrx_k), 512'(rxq[0].k));
            chk("rx_last", 512'(mrx_l), 512'(rxq[0].l));
            chk("rx_err", 512'(mrx_e), 512'(rxq[0].e));
            if (rxq[0].l) begin
                e_rxp += 1;
                e_rxe += 32'(rxq[0].e);
                e_rxb += 32'(rx_acc_of(rxq[0]));
            end
            void'(rxq.pop_front());
        end else begin
            chk("rx_idle", 512'(mrx_v), 512'd0);
        end
        if (held)
            chk("tx_hold", 512'({mtx_v, mtx_l, mtx_k, mtx_d}), 512'(held_vec));
        if (mtx_v && sink_rdy) begin
            if (txq.size() == 0) begin
                chk("tx_extra", 512'(mtx_v), 512'd0);
            end else begin
                chk("tx_data", mtx_d, txq[0].d);
                chk("tx_keep", 512'(mtx_k), 512'(txq[0].k));
                chk("tx_last", 512'(mtx_l), 512'(txq[0].l));
                last_tx_d = mtx_d;
                last_tx_k = mtx_k;
                if (txq[0].l) begin
                    e_txp += 1;
                    e_txb += 32'(txq[0].flen);
                end
                void'(txq.pop_front());
            end
        end
        held     = mtx_v && !sink_rdy;
        held_vec = {mtx_v, mtx_l, mtx_k, mtx_d};
    end

    // Frame length of an RX frame is tracked alongside its beats
    int rx_flen_acc = 0;
    function automatic int rx_acc_of(input rxb_t b);
        int t = rx_flen_acc + popc(b.k);
        rx_flen_acc = 0;
        return t;
    endfunction
    always @(negedge clk) begin
        #1;
        if (!rst_n) rx_flen_acc = 0;
        else if (mrx_v && !mrx_l) rx_flen_acc = rx_flen_acc + popc(mrx_k);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        int lens[10] = '{42, 64, 100, 128, 200, 20, 65, 130, 1, 300};
        rst_n = 1'b0;
        rx_v = 1'b0; rx_d = '0; rx_k = '0; rx_l = 1'b0; rx_e = 1'b0;
        tx_v = 1'b0; tx_d = '0; tx_k = '0; tx_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_tready", 512'(tx_rdy), 512'd0);
        chk("init_cnt", {c_rxp, c_rxe, c_rxb, c_txp, c_txb}, 512'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("init_tready_rise", 512'(tx_rdy), 512'd1);

        rx_frame(64, -1);
        rx_stop();
        drain();
        chk("lit_rx64_pkt", 512'(c_rxp), 512'd1);
        chk("lit_rx64_byte", 512'(c_rxb), 512'd64);
        chk("lit_rx64_err", 512'(c_rxe), 512'd0);

        rx_frame(60, -1);
        rx_stop();
        drain();
        chk("lit_rx60_err", 512'(c_rxe), 512'd1);

        rx_frame(1519, -1);
        rx_frame(1518, -1);
        rx_frame(192, 0);
        rx_frame(0, -1);
        rx_stop();
        drain();
        chk("lit_rx_pkt", 512'(c_rxp), 512'd6);
        chk("lit_rx_err", 512'(c_rxe), 512'd4);
        chk("lit_rx_byte", 512'(c_rxb), 512'd3353);

        tx_frame(42);
        tx_stop();
        drain();
        chk("lit_tx42_byte", 512'(c_txb), 512'd64);
        chk("lit_tx42_pkt", 512'(c_txp), 512'd1);
        chk("lit_tx42_keep", 512'(last_tx_k), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("lit_tx42_pad", 512'(last_tx_d[511:336]), 512'd0);

        do_reset();
        tog_en = 1'b1;
        foreach (lens[i]) tx_frame(lens[i]);
        tx_stop();
        drain();
        tog_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_tx10_pkt", 512'(c_txp), 512'd10);
        chk("lit_tx10_byte", 512'(c_txb), 512'd1179);

        rx_beat(rnd(), kmask(64), 1'b0, 1'b1);
        do_reset();
        tx_beat(rnd(), kmask(64), 1'b0);
        do_reset();
        rx_frame(64, -1);
        rx_stop();
        tx_frame(64);
        tx_stop();
        drain();
        chk("lit_post_rst_rxp", 512'(c_rxp), 512'd1);
        chk("lit_post_rst_rxe", 512'(c_rxe), 512'd0);
        chk("lit_post_rst_txp", 512'(c_txp), 512'd1);
        chk("lit_post_rst_txb", 512'(c_txb), 512'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
